// File: rtl/sib_tgl_capture_pkg.sv
// Shared definitions for the toggle-handshake bus capture block: state encoding,
// settle counter width and settle-interval helpers.
package sib_tgl_capture_pkg;

   localparam int CNT_W      = 4;
   localparam int SETTLE_MAX = (1 << CNT_W) - 1;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETTLE = 2'd1;
   localparam state_t ST_CAPT   = 2'd2;

   function automatic bit settle_cyc_legal(input int settle_cyc);
      return (settle_cyc >= 0) && (settle_cyc <= SETTLE_MAX);
   endfunction

   // Counter load value on request detection; zero settle bypasses the counter.
   function automatic logic [CNT_W-1:0] settle_load(input int settle_cyc);
      return (settle_cyc > 0) ? CNT_W'(settle_cyc - 1) : '0;
   endfunction

endpackage

// File: rtl/sib_tgl_edge_det.sv
// Toggle edge detector for handshake receivers: registers the (already
// synchronized) toggle and flags any level change against the previous cycle.
module sib_tgl_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic tgl,
   output logic tgl_q,
   output logic tgl_edge
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgl_q <= 1'b0;
      end else begin
         tgl_q <= tgl;
      end
   end

   assign tgl_edge = tgl ^ tgl_q;

endmodule

// File: rtl/sib_tgl_capture.sv
// Destination-side capture of a quasi-static bus under a toggle handshake.
// Optional parity check on the captured word is enabled by SIB_CAP_PARITY_EN.
module sib_tgl_capture
   import sib_tgl_capture_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int SETTLE_CYC = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_tgl_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              clr_ovr_i,
`ifdef SIB_CAP_PARITY_EN
   input  logic              par_i,
   output logic              perr_o,
`endif
   output logic [DWIDTH-1:0] dout_o,
   output logic              dvalid_o,
   output logic              ack_tgl_o,
   output logic              busy_o,
   output logic              ovr_o
);

   generate
      if (!settle_cyc_legal(SETTLE_CYC)) begin : g_bad_settle
         $error("sib_tgl_capture: SETTLE_CYC out of range 0..15");
      end
   endgenerate

   localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYC);
   localparam bit               SKIP_SETTLE = (SETTLE_CYC == 0);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             req_d;
   logic             req_edge;
   logic             capt_fire;
   logic             ovr_set;

   sib_tgl_edge_det u_edge_det (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .tgl      (req_tgl_i),
      .tgl_q    (req_d),
      .tgl_edge (req_edge)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         ST_IDLE: begin
            if (req_edge) begin
               if (SKIP_SETTLE) begin
                  state_nxt = ST_CAPT;
               end else begin
                  state_nxt = ST_SETTLE;
                  cnt_nxt   = SETTLE_LOAD;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt == '0) begin
               state_nxt = ST_CAPT;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_CAPT: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Edges arriving while busy are absorbed by the detector and only flagged.
   always_comb begin
      busy_o    = (state != ST_IDLE);
      capt_fire = (state == ST_CAPT);
      ovr_set   = req_edge && (state != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dout_o    <= '0;
         dvalid_o  <= 1'b0;
         ack_tgl_o <= 1'b0;
      end else begin
         dvalid_o <= capt_fire;
         if (capt_fire) begin
            dout_o    <= data_i;
            ack_tgl_o <= req_d;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovr_o <= 1'b0;
      end else if (ovr_set) begin
         ovr_o <= 1'b1;
      end else if (clr_ovr_i) begin
         ovr_o <= 1'b0;
      end
   end

`ifdef SIB_CAP_PARITY_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perr_o <= 1'b0;
      end else begin
         perr_o <= capt_fire ? (^{data_i, par_i}) : 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_sib_tgl_capture.sv
// Bench for sib_tgl_capture: two instances (settle 2 and settle 0) against a
// countdown-based transaction model, directed steps followed by random traffic.
module tb_sib_tgl_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req2;
   logic        req0;
   logic [31:0] data;
   logic        clr;
   logic [31:0] dout2, dout0;
   logic        dvalid2, dvalid0, ack2, ack0, busy2, busy0, ovr2, ovr0;
`ifdef SIB_CAP_PARITY_EN
   logic        par;
   logic        perr2, perr0;
   logic        m_perr [2];
`endif

   int          checks   = 0;
   int          failures = 0;

   // Model state, index 0 = SETTLE_CYC 2 instance, index 1 = SETTLE_CYC 0 instance.
   int          m_left   [2];
   logic        m_reqd   [2];
   logic [31:0] m_dout   [2];
   logic        m_dvalid [2];
   logic        m_ack    [2];
   logic        m_ovr    [2];

   always #5 clk = ~clk;

   sib_tgl_capture #(.DWIDTH(32), .SETTLE_CYC(2)) dut2 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_tgl_i (req2),
      .data_i    (data),
      .clr_ovr_i (clr),
`ifdef SIB_CAP_PARITY_EN
      .par_i     (par),
      .perr_o    (perr2),
`endif
      .dout_o    (dout2),
      .dvalid_o  (dvalid2),
      .ack_tgl_o (ack2),
      .busy_o    (busy2),
      .ovr_o     (ovr2)
   );

   sib_tgl_capture #(.DWIDTH(32), .SETTLE_CYC(0)) dut0 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_tgl_i (req0),
      .data_i    (data),
      .clr_ovr_i (clr),
`ifdef SIB_CAP_PARITY_EN
      .par_i     (par),
      .perr_o    (perr0),
`endif
      .dout_o    (dout0),
      .dvalid_o  (dvalid0),
      .ack_tgl_o (ack0),
      .busy_o    (busy0),
      .ovr_o     (ovr0)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_left[i]   = 0;
         m_reqd[i]   = 1'b0;
         m_dout[i]   = '0;
         m_dvalid[i] = 1'b0;
         m_ack[i]    = 1'b0;
         m_ovr[i]    = 1'b0;
`ifdef SIB_CAP_PARITY_EN
         m_perr[i]   = 1'b0;
`endif
      end
   endtask

   // A request seen while idle completes settle+1 edges later; anything seen while busy is overrun.
   task automatic model_step(input int i, input logic req, input int settle);
      bit edge_seen;
      bit was_busy;
      edge_seen   = (req != m_reqd[i]);
      was_busy    = (m_left[i] > 0);
      m_dvalid[i] = 1'b0;
`ifdef SIB_CAP_PARITY_EN
      m_perr[i]   = 1'b0;
`endif
      if (was_busy) begin
         m_left[i] = m_left[i] - 1;
         if (m_left[i] == 0) begin
            m_dout[i]   = data;
            m_dvalid[i] = 1'b1;
            m_ack[i]    = m_reqd[i];
`ifdef SIB_CAP_PARITY_EN
            m_perr[i]   = ^{data, par};
`endif
         end
      end else if (edge_seen) begin
         m_left[i] = settle + 1;
      end
      if (edge_seen && was_busy) m_ovr[i] = 1'b1;
      else if (clr)              m_ovr[i] = 1'b0;
      m_reqd[i] = req;
   endtask

   task automatic check_all();
      chk32("dout2",   dout2,   m_dout[0]);
      chk1 ("dvalid2", dvalid2, m_dvalid[0]);
      chk1 ("ack2",    ack2,    m_ack[0]);
      chk1 ("busy2",   busy2,   m_left[0] > 0);
      chk1 ("ovr2",    ovr2,    m_ovr[0]);
      chk32("dout0",   dout0,   m_dout[1]);
      chk1 ("dvalid0", dvalid0, m_dvalid[1]);
      chk1 ("ack0",    ack0,    m_ack[1]);
      chk1 ("busy0",   busy0,   m_left[1] > 0);
      chk1 ("ovr0",    ovr0,    m_ovr[1]);
`ifdef SIB_CAP_PARITY_EN
      chk1 ("perr2",   perr2,   m_perr[0]);
      chk1 ("perr0",   perr0,   m_perr[1]);
`endif
   endtask

   task automatic tick();
      model_step(0, req2, 2);
      model_step(1, req0, 0);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Called shortly after a rising edge: asserts reset between edges, releases at the falling edge.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk1("rst_now_dvalid2", dvalid2, 1'b0);
      chk1("rst_now_ack2",    ack2,    1'b0);
      chk1("rst_now_busy2",   busy2,   1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst_n = 1'b0;
      req2  = 1'b0;
      req0  = 1'b0;
      data  = '0;
      clr   = 1'b0;
`ifdef SIB_CAP_PARITY_EN
      par   = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk32("reset_dout2", dout2, 32'h0);
      chk1 ("reset_busy2", busy2, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Settle 2 capture of A5A5_0F0F, settle 0 capture in parallel.
      data = 32'hA5A5_0F0F;
      req2 = 1'b1;
      req0 = 1'b1;
      tick();
      chk1("t1_busy_e0", busy2, 1'b1);
      chk1("t1_dvalid_e0", dvalid2, 1'b0);
      tick();
      chk1("t1_dvalid0_e1", dvalid0, 1'b1);
      chk1("t1_dvalid_e1", dvalid2, 1'b0);
      tick();
      chk1("t1_busy_e2", busy2, 1'b1);
      chk1("t1_dvalid_e2", dvalid2, 1'b0);
      tick();
      chk1 ("t1_dvalid_e3", dvalid2, 1'b1);
      chk32("t1_dout_e3", dout2, 32'hA5A5_0F0F);
      chk1 ("t1_ack_e3", ack2, 1'b1);
      chk1 ("t1_busy_e3", busy2, 1'b0);
      tick();
      chk1("t1_dvalid_e4", dvalid2, 1'b0);

      // Settle 0, toggle 1->0.
      data = 32'h1234_5678;
      req0 = 1'b0;
      tick();
      chk1("t2_busy_e0", busy0, 1'b1);
      chk1("t2_dvalid_e0", dvalid0, 1'b0);
      tick();
      chk1 ("t2_dvalid_e1", dvalid0, 1'b1);
      chk1 ("t2_ack_e1", ack0, 1'b0);
      chk32("t2_dout_e1", dout0, 32'h1234_5678);
      tick();
      chk1("t2_dvalid_e2", dvalid0, 1'b0);

      // Overrun during settle, then clear.
      req2 = 1'b0;
      tick();
      req2 = 1'b1;
      tick();
      chk1("t3_ovr_set", ovr2, 1'b1);
      tick();
      tick();
      chk1("t3_dvalid", dvalid2, 1'b1);
      chk1("t3_ack_final", ack2, 1'b1);
      tick();
      chk1("t3_single_dvalid", dvalid2, 1'b0);
      chk1("t3_ovr_sticky", ovr2, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk1("t3_ovr_cleared", ovr2, 1'b0);

      // Overrun and clear in the same cycle: set wins.
      req2 = 1'b0;
      tick();
      req2 = 1'b1;
      clr  = 1'b1;
      tick();
      clr  = 1'b0;
      chk1("t4_set_wins", ovr2, 1'b1);
      repeat (3) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk1("t4_ovr_cleared", ovr2, 1'b0);

      // Reset in the middle of settle.
      req2 = 1'b0;
      tick();
      tick();
      chk1("t5_in_settle", busy2, 1'b1);
      async_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk1("t5_no_dvalid", dvalid2, 1'b0);
      end

`ifdef SIB_CAP_PARITY_EN
      data = 32'h0000_0001;
      par  = 1'b0;
      req0 = 1'b1;
      tick();
      tick();
      chk1("p1_dvalid", dvalid0, 1'b1);
      chk1("p1_perr", perr0, 1'b1);
      par  = 1'b1;
      req0 = 1'b0;
      tick();
      tick();
      chk1("p2_dvalid", dvalid0, 1'b1);
      chk1("p2_perr", perr0, 1'b0);
`endif

      // Random traffic with occasional resets (toggle may be high at release).
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(3) == 0) req2 = ~req2;
         if ($urandom_range(3) == 0) req0 = ~req0;
         if ($urandom_range(2) == 0) data = $urandom;
         clr = ($urandom_range(7) == 0);
`ifdef SIB_CAP_PARITY_EN
         par = 1'($urandom_range(1));
`endif
         if ($urandom_range(99) == 0) async_reset();
         else                         tick();
      end
      clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
